// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional subtract mode is enabled by SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshake bundle for the serial adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  ovf
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output ovf
    );

endinterface

// File: rtl/carry_lookahead_adder.sv
// 4-bit carry-lookahead slice used as the per-nibble adder.
// Purely combinational; carries come from generate/propagate terms.
module carry_lookahead_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    // Lookahead carries for all four bit positions in parallel
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ {c[3:1], ci};
        co   = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that runs one 4-bit CLA slice per cycle, LSB nibble first.
// SERIAL_ADDER_SUB_EN adds a sub input selecting A-B.
module nibble_serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);

    localparam int N     = nibble_count(WIDTH);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   b_in;
    logic               c_in;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic               c_nib;

    // Effective B and carry-in presented at operand capture
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_in = bus.sub ? ~bus.b : bus.b;
        c_in = bus.sub ? 1'b1 : bus.cin;
`else
        b_in = bus.b;
        c_in = bus.cin;
`endif
    end

    // Select the operand nibbles addressed by idx
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    carry_lookahead_adder u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_q),
        .s  (s_nib),
        .co (c_nib)
    );

    // FSM next state, operand capture and per-nibble result update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = b_in;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = s_nib;
                    end
                end
                carry_d = c_nib;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    cout_d  = c_nib;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                           && (s_nib[NIBBLE_W-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present operands and return just after the accepting edge
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
        int n;
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count cycles until out_valid, bounded
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec,
                          input logic eo);
        int lat;
        bus.out_ready = 1'b1;
        start(a, b, c);
        wait_out(lat);
        check({tag, "_lat"}, 32'(lat), 32'(N));
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int seen;
        int prev;
        int t;
        int n;
        logic [W-1:0] va [20];
        logic [W-1:0] vb [20];
        logic         vc [20];
        logic [W:0]   full;
        logic         eo;

        checks        = 0;
        errors        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("povf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("cin1", 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0);
        run_op("nadd", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure with stray in_valid pulses
        bus.out_ready = 1'b0;
        start(16'h00AA, 16'h0055, 1'b0);
        wait_out(lat);
        check("bp_lat", 32'(lat), 32'(N));
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_sum", 32'(bus.sum), 32'h00FF);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_valid", 32'(bus.out_valid), 32'd0);
        check("bp_rel_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("bp_no_ghost", 32'(seen), 32'd0);

        // Reset asserted while idx is 2
        start(16'h0F0F, 16'h0101, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_in_ready", 32'(bus.in_ready), 32'd1);
        check("mr_out_valid", 32'(bus.out_valid), 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) seen++;
        end
        check("mr_held", 32'(seen), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("mr_discard", 32'(seen), 32'd0);
        run_op("mr_next", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b1;
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        bus.sub = 1'b0;
`endif

        // Back-to-back random stream
        for (int i = 0; i < 20; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vc[i] = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.a        = va[0];
        bus.b        = vb[0];
        bus.cin      = vc[0];
        bus.in_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (!bus.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_ready", 32'(bus.in_ready), 32'd1);
            t = cyc;
            if (i > 0) check("b2b_interval", 32'(t - prev), 32'd6);
            prev = t;
            @(negedge clk);
            wait_out(lat);
            full = {1'b0, va[i]} + {1'b0, vb[i]} + {16'd0, vc[i]};
            eo   = (va[i][W-1] == vb[i][W-1]) && (full[W-1] != va[i][W-1]);
            check("b2b_sum", 32'(bus.sum), 32'(full[W-1:0]));
            check("b2b_cout", 32'(bus.cout), 32'(full[W]));
            check("b2b_ovf", 32'(bus.ovf), 32'(eo));
            if (i < 19) begin
                bus.a   = va[i+1];
                bus.b   = vb[i+1];
                bus.cin = vc[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
